// File: rtl/filter_feature_window_if.sv
// filter_feature_window_if
//   Bundles the sample stream and the window-result handshake of
//   filter_feature_window.
//   sample_in/sample_valid : signed filter output, one sample per valid cycle
//   feat_valid/feat_ready  : result handshake, transfer on valid & ready
//   ll_out/energy_out/peak_out : window features held while feat_valid=1
//   overrun                : sticky "a finished window was dropped"
//   master : sample source / result consumer side
//   slave  : feature extractor side
interface filter_feature_window_if;
   logic signed [31:0] sample_in;
   logic               sample_valid;
   logic               feat_valid;
   logic               feat_ready;
   logic        [47:0] ll_out;
   logic        [63:0] energy_out;
   logic        [31:0] peak_out;
   logic               overrun;

   modport master (
      output sample_in, sample_valid, feat_ready,
      input  feat_valid, ll_out, energy_out, peak_out, overrun
   );

   modport slave (
      input  sample_in, sample_valid, feat_ready,
      output feat_valid, ll_out, energy_out, peak_out, overrun
   );
endinterface

// File: rtl/filter_feature_window.sv
// filter_feature_window
//   Splits the IIR output stream into contiguous windows of WIN samples and
//   computes per window: line length sum|x[n]-x[n-1]|, saturating energy
//   sum(x^2 >> ESHIFT) and peak |x|. A one-deep result buffer lets the next
//   window accumulate while the previous result waits for the detector.
//   clk    : single clock, posedge
//   reset  : synchronous, active-low
//   fw     : sample stream in, feature handshake out (see interface)
//   WIN    : samples per window, power of two, 2..65536
//   ESHIFT : right shift of each squared sample, 0..63
module filter_feature_window #(
   parameter int unsigned WIN    = 256,
   parameter int unsigned ESHIFT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   filter_feature_window_if.slave  fw
);

   localparam int unsigned CW       = $clog2(WIN);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e             state_q,      state_d;
   logic        [47:0] acc_ll_q,     acc_ll_d;
   logic        [63:0] acc_en_q,     acc_en_d;
   logic        [31:0] acc_pk_q,     acc_pk_d;
   logic      [CW-1:0] cnt_q,        cnt_d;
   logic signed [31:0] prev_x_q,     prev_x_d;
   logic               have_prev_q,  have_prev_d;
   logic               feat_valid_q, feat_valid_d;
   logic        [47:0] ll_out_q,     ll_out_d;
   logic        [63:0] energy_out_q, energy_out_d;
   logic        [31:0] peak_out_q,   peak_out_d;
   logic               overrun_q,    overrun_d;

   // per-sample datapath
   logic signed [32:0] x33;
   logic signed [32:0] diff;
   logic        [32:0] abs_diff;
   logic        [47:0] ll_term;
   logic        [63:0] x64;
   logic        [63:0] sq;
   logic        [63:0] en_term;
   logic        [64:0] en_sum;
   logic        [32:0] abs_x;
   logic        [47:0] ll_next;
   logic        [63:0] en_next;
   logic        [31:0] pk_next;
   logic               done;
   logic               xfer;

   always_comb begin
      x33      = {fw.sample_in[31], fw.sample_in};
      // 33-bit difference cannot wrap: range is +-(2^32-1)
      diff     = x33 - {prev_x_q[31], prev_x_q};
      abs_diff = diff[32] ? 33'(-diff) : 33'(diff);
      ll_term  = have_prev_q ? {15'd0, abs_diff} : '0;

      // x^2 <= 2^62, so the low 64 bits of the signed product are exact
      x64      = {{32{fw.sample_in[31]}}, fw.sample_in};
      sq       = $signed(x64) * $signed(x64);
      en_term  = sq >> ESHIFT;
      en_sum   = {1'b0, acc_en_q} + {1'b0, en_term};

      // |x| at 33 bits so that |-2^31| = 2^31 is representable
      abs_x    = x33[32] ? 33'(-x33) : 33'(x33);

      ll_next  = acc_ll_q + ll_term;
      en_next  = en_sum[64] ? '1 : en_sum[63:0];
      pk_next  = (abs_x > {1'b0, acc_pk_q}) ? abs_x[31:0] : acc_pk_q;

      done     = fw.sample_valid && (cnt_q == CNT_LAST);
      xfer     = feat_valid_q && fw.feat_ready;
   end

   always_comb begin
      state_d      = state_q;
      acc_ll_d     = acc_ll_q;
      acc_en_d     = acc_en_q;
      acc_pk_d     = acc_pk_q;
      cnt_d        = cnt_q;
      prev_x_d     = prev_x_q;
      have_prev_d  = have_prev_q;
      feat_valid_d = feat_valid_q;
      ll_out_d     = ll_out_q;
      energy_out_d = energy_out_q;
      peak_out_d   = peak_out_q;
      overrun_d    = overrun_q;

      if (fw.sample_valid) begin
         prev_x_d    = fw.sample_in;
         have_prev_d = 1'b1;
         if (done) begin
            // the completing sample goes to the outputs via *_next;
            // accumulation restarts from zero on the following sample
            acc_ll_d = '0;
            acc_en_d = '0;
            acc_pk_d = '0;
            cnt_d    = '0;
         end else begin
            acc_ll_d = ll_next;
            acc_en_d = en_next;
            acc_pk_d = pk_next;
            cnt_d    = cnt_q + 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (fw.sample_valid) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (done) begin
               ll_out_d     = ll_next;
               energy_out_d = en_next;
               peak_out_d   = pk_next;
               feat_valid_d = 1'b1;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (done) begin
               if (xfer) begin
                  // buffer drains and refills on the same edge
                  ll_out_d     = ll_next;
                  energy_out_d = en_next;
                  peak_out_d   = pk_next;
               end else begin
                  overrun_d    = 1'b1;
               end
            end else if (xfer) begin
               feat_valid_d = 1'b0;
               state_d      = ACCUM;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         acc_ll_q     <= '0;
         acc_en_q     <= '0;
         acc_pk_q     <= '0;
         cnt_q        <= '0;
         prev_x_q     <= '0;
         have_prev_q  <= 1'b0;
         feat_valid_q <= 1'b0;
         ll_out_q     <= '0;
         energy_out_q <= '0;
         peak_out_q   <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_ll_q     <= acc_ll_d;
         acc_en_q     <= acc_en_d;
         acc_pk_q     <= acc_pk_d;
         cnt_q        <= cnt_d;
         prev_x_q     <= prev_x_d;
         have_prev_q  <= have_prev_d;
         feat_valid_q <= feat_valid_d;
         ll_out_q     <= ll_out_d;
         energy_out_q <= energy_out_d;
         peak_out_q   <= peak_out_d;
         overrun_q    <= overrun_d;
      end
   end

   assign fw.feat_valid = feat_valid_q;
   assign fw.ll_out     = ll_out_q;
   assign fw.energy_out = energy_out_q;
   assign fw.peak_out   = peak_out_q;
   assign fw.overrun    = overrun_q;

endmodule
